// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a single-ported fixed-latency memory
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic [XLEN-1:0] if_rdata_o,
   output logic            if_valid_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [XLEN-1:0] d_addr_i,
   input  logic [XLEN-1:0] d_wdata_i,
   output logic [XLEN-1:0] d_rdata_o,
   output logic            d_valid_o,
   output logic            d_err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            busy_o
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);
   localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic [SW-1:0] streak;
   logic          own_data;
   logic          acc_we;
   logic          grant_any;
   logic          grant_data;
   logic          misaligned;

   // Arbitration and next-state: data wins unless the fetch has waited STARVE_LIMIT data grants.
   always_comb begin
      state_next = state;
      grant_any  = 1'b0;
      grant_data = 1'b0;
      misaligned = 1'b0;
      case (state)
         IDLE: begin
            if (d_req_i || if_req_i) begin
               grant_any  = 1'b1;
               grant_data = d_req_i && (!if_req_i || (streak < LIMIT));
               misaligned = grant_data && (d_addr_i[1:0] != 2'b00);
               state_next = misaligned ? RESP : ISSUE;
            end
         end
         ISSUE:   state_next = WAIT;
         WAIT:    if (cnt == '0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register plus all registered outputs; pulses default low every cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         streak      <= '0;
         own_data    <= 1'b0;
         acc_we      <= 1'b0;
         if_rdata_o  <= '0;
         if_valid_o  <= 1'b0;
         d_rdata_o   <= '0;
         d_valid_o   <= 1'b0;
         d_err_o     <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         busy_o      <= 1'b0;
      end else begin
         state      <= state_next;
         busy_o     <= (state_next != IDLE);
         mem_req_o  <= 1'b0;
         mem_we_o   <= 1'b0;
         if_valid_o <= 1'b0;
         d_valid_o  <= 1'b0;
         d_err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  own_data   <= grant_data;
                  acc_we     <= grant_data && d_we_i;
                  mem_addr_o <= grant_data ? d_addr_i : if_addr_i;
                  if (grant_data) mem_wdata_o <= d_wdata_i;
                  if (grant_data && if_req_i) begin
                     if (streak < LIMIT) streak <= streak + 1'b1;
                  end else begin
                     streak <= '0;
                  end
                  if (misaligned) begin
                     d_valid_o <= 1'b1;
                     d_err_o   <= 1'b1;
                  end else begin
                     mem_req_o <= 1'b1;
                     mem_we_o  <= grant_data && d_we_i;
                  end
               end
            end
            ISSUE: cnt <= CNT_LOAD;
            WAIT: begin
               if (cnt == '0) begin
                  if (own_data) begin
                     d_valid_o <= 1'b1;
                     if (!acc_we) d_rdata_o <= mem_rdata_i;
                  end else begin
                     if_valid_o <= 1'b1;
                     if_rdata_o <= mem_rdata_i;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int L = 2;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   mem_port_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_rdata_o(d_rdata), .d_valid_o(d_valid), .d_err_o(d_err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   typedef struct {
      int          kind;   // 0 mem access, 1 fetch valid, 2 data valid
      int          cyc;
      logic [31:0] a;      // address or rdata
      logic [31:0] b;      // store data
      logic        c;      // we or err
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   base;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int c, input logic [31:0] a,
                            input logic [31:0] b, input logic e);
      exp_t x;
      x.kind = kind; x.cyc = c; x.a = a; x.b = b; x.c = e;
      q.push_back(x);
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h10) ? 32'h00500093 : ~a;
   endfunction

   // Memory model: read data appears L cycles after the access strobe.
   logic        pv[L+1];
   logic [31:0] pa[L+1];
   initial begin
      for (int i = 0; i <= L; i++) begin pv[i] = 1'b0; pa[i] = '0; end
      mem_rdata = 32'hBAD0BAD0;
      forever begin
         @(negedge clk);
         for (int i = L; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
         pv[0] = mem_req && !mem_we;
         pa[0] = mem_addr;
         mem_rdata = pv[L] ? mem_word(pa[L]) : 32'hBAD0BAD0;
      end
   end

   // Monitor: every DUT strobe pops one expected event and compares it.
   initial begin
      exp_t e;
      int   k;
      forever begin
         @(negedge clk);
         if (!rst && (mem_req || if_valid || d_valid)) begin
            if (if_valid || d_valid) check("valid_exclusive", 32'(if_valid & d_valid), 32'd0);
            if (q.size() == 0) begin
               check("unexpected_event", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               k = mem_req ? 0 : (if_valid ? 1 : 2);
               check("event_kind", 32'(k), 32'(e.kind));
               check("event_cycle", 32'(cyc), 32'(e.cyc));
               if (e.kind == 0) begin
                  check("mem_addr", mem_addr, e.a);
                  check("mem_we", 32'(mem_we), 32'(e.c));
                  if (e.c) check("mem_wdata", mem_wdata, e.b);
               end else if (e.kind == 1) begin
                  check("if_rdata", if_rdata, e.a);
               end else begin
                  check("d_rdata", d_rdata, e.a);
                  check("d_err", 32'(d_err), 32'(e.c));
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      @(negedge clk); @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_valids", 32'({if_valid, d_valid, d_err}), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_rdata", if_rdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      goto(cyc + 1);

      // single fetch with busy profile
      base = cyc;
      if_req = 1; if_addr = 32'h10;
      expect_ev(0, base + 1, 32'h10, 0, 0);
      expect_ev(1, base + 4, 32'h00500093, 0, 0);
      for (int k = 0; k <= 5; k++) begin
         goto(base + k);
         if (k == 4) if_req = 0;
         @(negedge clk);
         check($sformatf("busy_c%0d", k), 32'(busy), 32'((k >= 1 && k <= 4) ? 1 : 0));
      end
      goto(base + 6);

      // simultaneous load and fetch: data first
      base = cyc;
      d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h20;
      expect_ev(0, base + 1, 32'h100, 0, 0);
      expect_ev(2, base + 4, 32'hFFFFFEFF, 0, 0);
      expect_ev(0, base + 6, 32'h20, 0, 0);
      expect_ev(1, base + 9, 32'hFFFFFFDF, 0, 0);
      goto(base + 4); d_req = 0;
      goto(base + 9); if_req = 0;
      goto(base + 11);

      // store leaves d_rdata untouched
      base = cyc;
      d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      expect_ev(0, base + 1, 32'h100, 32'hDEADBEEF, 1);
      expect_ev(2, base + 4, 32'hFFFFFEFF, 0, 0);
      goto(base + 4); d_req = 0; d_we = 0;
      goto(base + 6);

      // misaligned, then aligned load
      base = cyc;
      d_req = 1; d_addr = 32'h102;
      expect_ev(2, base + 1, 32'hFFFFFEFF, 0, 1);
      goto(base + 1); d_req = 0;
      goto(base + 2);
      base = cyc;
      d_req = 1; d_addr = 32'h104;
      expect_ev(0, base + 1, 32'h104, 0, 0);
      expect_ev(2, base + 4, 32'hFFFFFEFB, 0, 0);
      goto(base + 4); d_req = 0;
      goto(base + 6);

      // starvation bound: D,D,D,D,F,D,D,D,D,F
      base = cyc;
      if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h200;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) begin
            expect_ev(0, base + 5*k + 1, 32'h40, 0, 0);
            expect_ev(1, base + 5*k + 4, 32'hFFFFFFBF, 0, 0);
         end else begin
            expect_ev(0, base + 5*k + 1, 32'h200, 0, 0);
            expect_ev(2, base + 5*k + 4, 32'hFFFFFDFF, 0, 0);
         end
      end
      goto(base + 49); if_req = 0; d_req = 0;
      goto(base + 51);

      // reset during WAIT aborts the fetch
      base = cyc;
      if_req = 1; if_addr = 32'h30;
      expect_ev(0, base + 1, 32'h30, 0, 0);
      goto(base + 2);
      rst = 1; if_req = 0;
      @(negedge clk);
      check("midrst_mem_req_we", 32'({mem_req, mem_we}), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_valids", 32'({if_valid, d_valid, d_err}), 0);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_d_rdata", d_rdata, 0);
      goto(base + 3); rst = 0;
      goto(base + 8);
      base = cyc;
      if_req = 1; if_addr = 32'h10;
      expect_ev(0, base + 1, 32'h10, 0, 0);
      expect_ev(1, base + 4, 32'h00500093, 0, 0);
      goto(base + 4); if_req = 0;
      goto(base + 8);

      check("events_outstanding", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
